// File: rtl/eth_rx_frame_parser.sv
// Ethernet RX frame parser: captures an HDR_LEN-byte header, forwards payload and reports per-frame status.
// Define ETH_RX_MAC_FILTER_EN to enable destination MAC filtering (otherwise every frame is accepted).
module eth_rx_frame_parser #(
  parameter int HDR_LEN = 14,
  parameter int MIN_LEN = 50,
  parameter int MAX_LEN = 1504,
  parameter int CNT_W   = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             data_in,
  input  logic                   data_in_vld,
  input  logic                   byte_in_vld,
  input  logic                   crc_vld,
  input  logic [47:0]            mac_addr,
  input  logic                   promisc,
  output logic [7:0]             data_out,
  output logic                   data_out_vld,
  output logic [8*HDR_LEN-1:0]   hdr,
  output logic                   hdr_vld,
  output logic [CNT_W-1:0]       stat_len,
  output logic                   stat_crc_err,
  output logic                   stat_runt,
  output logic                   stat_ovf,
  output logic                   stat_vld
);

  localparam int HW = 8 * HDR_LEN;

  typedef enum logic [2:0] {S_WAIT, S_IDLE, S_HDR, S_PAY, S_DROP} state_t;

  state_t             state_q, state_d;
  logic [4:0]         hcnt_q, hcnt_d;
  logic [HW-9:0]      hbuf_q, hbuf_d;
  logic [HW-1:0]      hdr_q, hdr_d;
  logic               hdr_vld_q, hdr_vld_d;
  logic [CNT_W-1:0]   pay_cnt_q, pay_cnt_d;
  logic               ovf_q, ovf_d, rpt_q, rpt_d, crc_last_q, crc_last_d;
  logic [CNT_W-1:0]   stat_len_q, stat_len_d;
  logic               crc_err_q, crc_err_d, runt_q, runt_d, sovf_q, sovf_d;
  logic               stat_vld_q, stat_vld_d;

  logic [HW-1:0]      hdr_next;
  logic [47:0]        dest;
  logic               addr_pass;
  logic               pay_full;

  // Header shifts in MSB-first, so byte 0 lands in the top byte after HDR_LEN bytes.
  assign hdr_next = {hbuf_q, data_in};
  assign dest     = hdr_next[HW-1 -: 48];

`ifdef ETH_RX_MAC_FILTER_EN
  assign addr_pass = promisc | (dest == mac_addr) | (&dest);
`else
  logic unused_filter;
  assign addr_pass     = 1'b1;
  assign unused_filter = ^{mac_addr, promisc, dest};
`endif

  assign pay_full     = (pay_cnt_q == CNT_W'(MAX_LEN));
  assign data_out     = data_in;
  assign data_out_vld = (state_q == S_PAY) & byte_in_vld & data_in_vld & ~pay_full;

  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    hbuf_d     = hbuf_q;
    hdr_d      = hdr_q;
    hdr_vld_d  = 1'b0;
    pay_cnt_d  = pay_cnt_q;
    ovf_d      = ovf_q;
    rpt_d      = rpt_q;
    crc_last_d = crc_last_q;
    stat_len_d = stat_len_q;
    crc_err_d  = crc_err_q;
    runt_d     = runt_q;
    sovf_d     = sovf_q;
    stat_vld_d = 1'b0;

    case (state_q)
      S_WAIT: if (!data_in_vld) state_d = S_IDLE;
      S_IDLE: begin
        if (data_in_vld && byte_in_vld) begin
          hbuf_d  = hdr_next[HW-9:0];
          hcnt_d  = 5'd1;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (data_in_vld && byte_in_vld) begin
          hbuf_d = hdr_next[HW-9:0];
          hcnt_d = hcnt_q + 5'd1;
          if (hcnt_q == 5'(HDR_LEN - 1)) begin
            if (addr_pass) begin
              hdr_d     = hdr_next;
              hdr_vld_d = 1'b1;
              state_d   = S_PAY;
            end else begin
              state_d = S_DROP;
            end
          end
        end
      end
      S_PAY: begin
        if (data_in_vld && byte_in_vld) begin
          if (pay_full) begin
            ovf_d   = 1'b1;
            rpt_d   = 1'b1;
            state_d = S_DROP;
          end else begin
            pay_cnt_d  = pay_cnt_q + CNT_W'(1);
            crc_last_d = crc_vld;
          end
        end
      end
      S_DROP: ;
      default: state_d = S_WAIT;
    endcase

    // Frame end overrides whatever the byte handling above decided.
    if (!data_in_vld && (state_q inside {S_HDR, S_PAY, S_DROP})) begin
      if (state_q == S_HDR) begin
        stat_len_d = '0;
        crc_err_d  = 1'b1;
        runt_d     = 1'b1;
        sovf_d     = 1'b0;
        stat_vld_d = 1'b1;
      end else if (state_q == S_PAY || rpt_q) begin
        stat_len_d = pay_cnt_q;
        crc_err_d  = ~crc_last_q;
        runt_d     = (pay_cnt_q < CNT_W'(MIN_LEN));
        sovf_d     = ovf_q;
        stat_vld_d = 1'b1;
      end
      state_d    = S_IDLE;
      pay_cnt_d  = '0;
      ovf_d      = 1'b0;
      rpt_d      = 1'b0;
      crc_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_WAIT;
      hcnt_q     <= '0;
      hdr_q      <= '0;
      hdr_vld_q  <= 1'b0;
      pay_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      rpt_q      <= 1'b0;
      crc_last_q <= 1'b0;
      stat_len_q <= '0;
      crc_err_q  <= 1'b0;
      runt_q     <= 1'b0;
      sovf_q     <= 1'b0;
      stat_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      hdr_q      <= hdr_d;
      hdr_vld_q  <= hdr_vld_d;
      pay_cnt_q  <= pay_cnt_d;
      ovf_q      <= ovf_d;
      rpt_q      <= rpt_d;
      crc_last_q <= crc_last_d;
      stat_len_q <= stat_len_d;
      crc_err_q  <= crc_err_d;
      runt_q     <= runt_d;
      sovf_q     <= sovf_d;
      stat_vld_q <= stat_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    hbuf_q <= hbuf_d;
  end

  assign hdr          = hdr_q;
  assign hdr_vld      = hdr_vld_q;
  assign stat_len     = stat_len_q;
  assign stat_crc_err = crc_err_q;
  assign stat_runt    = runt_q;
  assign stat_ovf     = sovf_q;
  assign stat_vld     = stat_vld_q;

endmodule

// File: tb/tb_eth_rx_frame_parser.sv
// Directed bench for eth_rx_frame_parser with a frame-level expectation model and per-cycle compare.
module tb_eth_rx_frame_parser;
  localparam int HDR_LEN = 14;
  localparam int MIN_LEN = 50;
  localparam int MAX_LEN = 1504;
  localparam int CNT_W   = 11;
  localparam logic [47:0] MAC   = 48'h020000000001;
  localparam logic [47:0] OTHER = 48'h020000000002;
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
`ifdef ETH_RX_MAC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  typedef struct packed {
    logic [CNT_W-1:0] len;
    logic             crc;
    logic             runt;
    logic             ovf;
  } stat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n = 1'b0;
  logic [7:0]           data_in = 8'h00;
  logic                 data_in_vld = 1'b0;
  logic                 byte_in_vld = 1'b0;
  logic                 crc_vld = 1'b0;
  logic [47:0]          mac_addr = MAC;
  logic                 promisc = 1'b0;
  logic [7:0]           data_out;
  logic                 data_out_vld;
  logic [8*HDR_LEN-1:0] hdr;
  logic                 hdr_vld;
  logic [CNT_W-1:0]     stat_len;
  logic                 stat_crc_err, stat_runt, stat_ovf, stat_vld;

  eth_rx_frame_parser #(.HDR_LEN(HDR_LEN), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_in_vld(data_in_vld),
    .byte_in_vld(byte_in_vld), .crc_vld(crc_vld), .mac_addr(mac_addr), .promisc(promisc),
    .data_out(data_out), .data_out_vld(data_out_vld), .hdr(hdr), .hdr_vld(hdr_vld),
    .stat_len(stat_len), .stat_crc_err(stat_crc_err), .stat_runt(stat_runt),
    .stat_ovf(stat_ovf), .stat_vld(stat_vld)
  );

  int n_cmp = 0, n_fail = 0;
  int dv_cnt = 0, hv_cnt = 0, sv_cnt = 0;
  logic chk_en = 1'b0;

  logic                 exp_dvld = 1'b0, exp_hvld = 1'b0, exp_svld = 1'b0;
  logic [7:0]           exp_data = 8'h00;
  logic [8*HDR_LEN-1:0] cur_hdr = '0, pend_hdr = '0, nxt_hdr = '0;
  stat_t                cur_st = '0, pend_st = '0, nxt_st = '0;
  logic                 pend_h = 1'b0, pend_s = 1'b0, pend_rst = 1'b1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("data_out_vld", data_out_vld, exp_dvld);
      chk("data_out", data_out, exp_data);
      chk("hdr_vld", hdr_vld, exp_hvld);
      chk("hdr", hdr, cur_hdr);
      chk("stat_vld", stat_vld, exp_svld);
      chk("stat_fields", {stat_len, stat_crc_err, stat_runt, stat_ovf}, cur_st);
      if (data_out_vld) dv_cnt++;
      if (hdr_vld) hv_cnt++;
      if (stat_vld) sv_cnt++;
    end
  end

  // One clock cycle of stimulus; registered expectations lag the inputs that cause them by one tick.
  task automatic tick(input logic rst, input logic v, input logic b, input logic [7:0] d,
                      input logic c, input logic edv, input logic nh, input logic ns);
    exp_hvld = pend_h;
    exp_svld = pend_s;
    if (pend_rst) begin
      cur_hdr = '0;
      cur_st  = '0;
    end else begin
      if (pend_h) cur_hdr = pend_hdr;
      if (pend_s) cur_st = pend_st;
    end
    rst_n = ~rst; data_in_vld = v; byte_in_vld = b; data_in = d; crc_vld = c;
    exp_data = d;
    exp_dvld = edv;
    pend_h   = nh & ~rst;
    pend_s   = ns & ~rst;
    pend_rst = rst;
    pend_hdr = nxt_hdr;
    pend_st  = nxt_st;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [7:0] fbyte(input logic [47:0] dest, input int i, input logic [7:0] seed);
    if (i < 6) return dest[47-8*i -: 8];
    return 8'(i * 37) + seed;
  endfunction

  // Sends n bytes (header + payload); abort >= 0 stops before byte 'abort' without ending the frame.
  task automatic send_frame(input logic [47:0] dest, input int n, input logic crc_good,
                            input logic prom, input bit spaced, input logic [7:0] seed,
                            input int abort, input logic end_b);
    logic                 acc, c, fwd, nh, lastcrc;
    logic [7:0]           b;
    logic [8*HDR_LEN-1:0] hv;
    int                   npay, len;
    acc     = !FILT || (dest == MAC) || (dest == BCAST) || prom;
    promisc = prom;
    lastcrc = 1'b0;
    hv      = '0;
    npay    = (n > HDR_LEN) ? n - HDR_LEN : 0;
    for (int i = 0; i < n; i++) begin
      if (i == abort) return;
      b = fbyte(dest, i, seed);
      c = (i == n - 1) ? crc_good : (i % 3 == 0);
      if (i < HDR_LEN) hv[8*(HDR_LEN-1-i) +: 8] = b;
      fwd = acc && (i >= HDR_LEN) && (i - HDR_LEN < MAX_LEN);
      if (fwd) lastcrc = c;
      nh = acc && (i == HDR_LEN - 1);
      if (nh) nxt_hdr = hv;
      tick(1'b0, 1'b1, 1'b1, b, c, fwd, nh, 1'b0);
      if (spaced) tick(1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    if (n < HDR_LEN) begin
      nxt_st = {CNT_W'(0), 1'b1, 1'b1, 1'b0};
      tick(1'b0, 1'b0, end_b, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b1);
    end else if (acc) begin
      len    = (npay > MAX_LEN) ? MAX_LEN : npay;
      nxt_st = {CNT_W'(len), ~lastcrc, (len < MIN_LEN), (npay > MAX_LEN)};
      tick(1'b0, 1'b0, end_b, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b1);
    end else begin
      tick(1'b0, 1'b0, end_b, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int dv0, hv0, sv0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    repeat (3) tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("reset_hdr", hdr, 0);
    chk("reset_stat_vld", stat_vld, 0);
    chk("reset_stat_len", stat_len, 0);
    chk("reset_dvld", data_out_vld, 0);

    // Unicast match, bytes spaced like an MII assembler would deliver them
    dv0 = dv_cnt; hv0 = hv_cnt; sv0 = sv_cnt;
    send_frame(MAC, 74, 1'b1, 1'b0, 1'b1, 8'h11, -1, 1'b0);
    idle(2);
    chk("uni_dv_count", dv_cnt - dv0, 60);
    chk("uni_hv_count", hv_cnt - hv0, 1);
    chk("uni_sv_count", sv_cnt - sv0, 1);
    chk("uni_stat_len", stat_len, 60);
    chk("uni_flags", {stat_crc_err, stat_runt, stat_ovf}, 3'b000);
    chk("uni_hdr_dest", hdr[111:64], 48'h020000000001);

    // Other station, not promiscuous
    dv0 = dv_cnt; hv0 = hv_cnt; sv0 = sv_cnt;
    send_frame(OTHER, 74, 1'b1, 1'b0, 1'b0, 8'h22, -1, 1'b0);
    idle(2);
    chk("filt_hv_count", hv_cnt - hv0, FILT ? 0 : 1);
    chk("filt_dv_count", dv_cnt - dv0, FILT ? 0 : 60);
    chk("filt_sv_count", sv_cnt - sv0, FILT ? 0 : 1);

    hv0 = hv_cnt; sv0 = sv_cnt;
    send_frame(OTHER, 74, 1'b1, 1'b1, 1'b0, 8'h33, -1, 1'b0);
    idle(2);
    chk("promisc_hv_count", hv_cnt - hv0, 1);
    chk("promisc_sv_count", sv_cnt - sv0, 1);

    hv0 = hv_cnt; sv0 = sv_cnt;
    send_frame(BCAST, 74, 1'b1, 1'b0, 1'b0, 8'h44, -1, 1'b0);
    idle(2);
    chk("bcast_hv_count", hv_cnt - hv0, 1);
    chk("bcast_sv_count", sv_cnt - sv0, 1);

    // Runt in the header
    hv0 = hv_cnt; sv0 = sv_cnt;
    send_frame(MAC, 10, 1'b1, 1'b0, 1'b0, 8'h55, -1, 1'b0);
    idle(2);
    chk("short_hv_count", hv_cnt - hv0, 0);
    chk("short_sv_count", sv_cnt - sv0, 1);
    chk("short_stat", {stat_len, stat_crc_err, stat_runt, stat_ovf}, {CNT_W'(0), 3'b110});

    // 40 payload bytes with bad CRC
    send_frame(MAC, 54, 1'b0, 1'b0, 1'b0, 8'h66, -1, 1'b0);
    idle(2);
    chk("runt_stat", {stat_len, stat_crc_err, stat_runt, stat_ovf}, {CNT_W'(40), 3'b110});

    // Oversize: 1600 payload bytes
    dv0 = dv_cnt; sv0 = sv_cnt;
    send_frame(MAC, HDR_LEN + 1600, 1'b1, 1'b0, 1'b0, 8'h77, -1, 1'b0);
    idle(2);
    chk("ovf_dv_count", dv_cnt - dv0, 1504);
    chk("ovf_sv_count", sv_cnt - sv0, 1);
    chk("ovf_stat_len", stat_len, 1504);
    chk("ovf_flag", stat_ovf, 1);

    // Reset during payload, data_in_vld held high through release
    send_frame(MAC, 60, 1'b1, 1'b0, 1'b0, 8'h88, 34, 1'b0);
    dv0 = dv_cnt; hv0 = hv_cnt; sv0 = sv_cnt;
    repeat (2) tick(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) tick(1'b0, 1'b1, 1'b1, 8'(k + 8'hA0), 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("rst_dv_count", dv_cnt - dv0, 0);
    chk("rst_hv_count", hv_cnt - hv0, 0);
    chk("rst_sv_count", sv_cnt - sv0, 0);
    chk("rst_stat_len", stat_len, 0);

    sv0 = sv_cnt;
    send_frame(MAC, 64, 1'b1, 1'b0, 1'b1, 8'h99, -1, 1'b0);
    idle(2);
    chk("post_rst_sv_count", sv_cnt - sv0, 1);
    chk("post_rst_stat_len", stat_len, 50);

    // Back-to-back, single gap cycle that also carries an ignored byte strobe
    hv0 = hv_cnt; sv0 = sv_cnt;
    send_frame(MAC, 64, 1'b1, 1'b0, 1'b0, 8'hAA, -1, 1'b1);
    send_frame(BCAST, 64, 1'b0, 1'b0, 1'b0, 8'hBB, -1, 1'b0);
    idle(3);
    chk("b2b_hv_count", hv_cnt - hv0, 2);
    chk("b2b_sv_count", sv_cnt - sv0, 2);
    chk("b2b_stat", {stat_len, stat_crc_err, stat_runt, stat_ovf}, {CNT_W'(50), 3'b100});

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
